// File: rtl/week_5_gate_bist.sv
// Built-in self test for a 2-input gate: walks {a,b} through 00..11, waits SETTLE_CYCLES, compares y with TRUTH.
// Latency: 2+SETTLE_CYCLES cycles per vector, done pulses 4*(2+SETTLE_CYCLES) edges after start accept.
// Backpressure: none; start is only accepted in IDLE. Optional GATE_BIST_LOOP_EN adds loop/run_count.
module week_5_gate_bist #(
    parameter logic [3:0] TRUTH         = 4'b0111,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef GATE_BIST_LOOP_EN
    input  logic        loop,
    output logic [15:0] run_count,
`endif
    output logic        a_out,
    output logic        b_out,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  pass_count,
    output logic [2:0]  fail_count,
    output logic [3:0]  fail_mask
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] settle_cnt;
    logic       hit;

    assign hit = (y_in == TRUTH[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            pass_count <= 3'd0;
            fail_count <= 3'd0;
            fail_mask  <= 4'd0;
`ifdef GATE_BIST_LOOP_EN
            run_count  <= 16'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= APPLY;
                        busy       <= 1'b1;
                        idx        <= 2'd0;
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                        pass       <= 1'b0;
                        pass_count <= 3'd0;
                        fail_count <= 3'd0;
                        fail_mask  <= 4'd0;
                    end
                end
                APPLY: begin
                    settle_cnt <= 4'd0;
                    state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (hit) begin
                        pass_count <= pass_count + 3'd1;
                    end else begin
                        fail_count     <= fail_count + 3'd1;
                        fail_mask[idx] <= 1'b1;
                    end
                    if (idx == 2'd3) begin
                        // fail_count has not absorbed this vector yet, so fold in the live compare
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= hit && (fail_count == 3'd0);
`ifdef GATE_BIST_LOOP_EN
                        if (run_count != 16'hFFFF) begin
                            run_count <= run_count + 16'd1;
                        end
`endif
                    end else begin
                        idx            <= idx + 2'd1;
                        {a_out, b_out} <= idx + 2'd1;
                        state          <= APPLY;
                    end
                end
                DONE: begin
`ifdef GATE_BIST_LOOP_EN
                    if (loop) begin
                        state      <= APPLY;
                        idx        <= 2'd0;
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                        pass_count <= 3'd0;
                        fail_count <= 3'd0;
                        fail_mask  <= 4'd0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
